// File: rtl/npc_bpred.sv
// npc_bpred: predictive next-PC unit for the pipelined MIPS core.
// Holds the fetch PC and predicts the next fetch address from a direct-mapped
// BTB with 2-bit saturating counters. Branches and jumps are resolved in ID;
// a misprediction redirects fetch and raises flush.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   harzard             fetch/decode stall; PC holds, resolution suppressed
//   pc                  current fetch PC (register)
//   pred_taken          BTB prediction for pc
//   pred_target         predicted target for pc (0 on a BTB miss)
//   id_valid            ID instruction is real (not a bubble)
//   id_pc               PC of the ID instruction
//   id_npcop            next-PC op (NPC_* encodings)
//   id_zero             comparator equal flag
//   id_imm26, id_imm16  jump index, branch offset
//   id_rs               register target for JR/JALR
//   id_pred_taken       prediction carried with the ID instruction
//   id_pred_target      predicted target carried with the ID instruction
//   flush               kill the IF instruction (combinational)
//   mispred_cnt         saturating misprediction count

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'd0
`define NPC_BRANCH 3'd1
`define NPC_BNE    3'd2
`define NPC_JUMP   3'd3
`define NPC_JAL    3'd4
`define NPC_JR     3'd5
`define NPC_JALR   3'd6
`endif

module npc_bpred #(
  parameter int          ADDR_W      = 32,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [1:0]  CNT_INIT    = 2'b01,
  parameter int          STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              harzard,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [2:0]        id_npcop,
  input  logic              id_zero,
  input  logic [25:0]       id_imm26,
  input  logic [15:0]       id_imm16,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pred_target,
  output logic              flush,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag   [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_tgt   [BTB_ENTRIES];
  logic [1:0]        btb_cnt   [BTB_ENTRIES];

  logic [ADDR_W-1:0] pc_q;
  logic [STAT_W-1:0] mis_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx       = pc_q[IDX_W+1:2];
  assign f_tag       = pc_q[ADDR_W-1:IDX_W+2];
  assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && btb_cnt[f_idx][1];
  assign pred_target = f_hit ? btb_tgt[f_idx] : '0;

  // ID-side resolution
  logic              res;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] id_pcplus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] actual_next;
  logic              mispredict;

  assign id_pcplus4 = id_pc + ADDR_W'(4);
  assign br_off     = {{(ADDR_W-18){id_imm16[15]}}, id_imm16, 2'b00};
  assign res        = id_valid && !harzard && (id_npcop != `NPC_PLUS4);

  always_comb begin
    taken  = 1'b0;
    target = id_pcplus4;
    case (id_npcop)
      `NPC_BRANCH: begin
        taken  = id_zero;
        target = id_pcplus4 + br_off;
      end
      `NPC_BNE: begin
        taken  = !id_zero;
        target = id_pcplus4 + br_off;
      end
      `NPC_JUMP, `NPC_JAL: begin
        taken  = 1'b1;
        target = {id_pcplus4[ADDR_W-1:28], id_imm26, 2'b00};
      end
      `NPC_JR, `NPC_JALR: begin
        taken  = 1'b1;
        target = id_rs;
      end
      default: begin
        taken  = 1'b0;
        target = id_pcplus4;
      end
    endcase
  end

  assign actual_next = taken ? target : id_pcplus4;
  assign mispredict  = res && ((id_pred_taken != taken) ||
                               (taken && (id_pred_target != target)));
  // Gated so flush stays low while the reset is held.
  assign flush       = mispredict && !rst;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign u_idx = id_pc[IDX_W+1:2];
  assign u_tag = id_pc[ADDR_W-1:IDX_W+2];
  assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_PC);
      mis_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
        btb_cnt[i]   <= CNT_INIT;
      end
    end else begin
      if (mispredict)
        pc_q <= actual_next;
      else if (!harzard)
        pc_q <= pred_taken ? pred_target : pc_q + ADDR_W'(4);

      if (mispredict && (mis_q != {STAT_W{1'b1}}))
        mis_q <= mis_q + STAT_W'(1);

      if (res) begin
        if (u_hit) begin
          if (taken) begin
            if (btb_cnt[u_idx] != 2'b11)
              btb_cnt[u_idx] <= btb_cnt[u_idx] + 2'b01;
            btb_tgt[u_idx] <= target;
          end else if (btb_cnt[u_idx] != 2'b00) begin
            btb_cnt[u_idx] <= btb_cnt[u_idx] - 2'b01;
          end
        end else if (taken) begin
          // Allocation replaces whatever alias held this index.
          btb_valid[u_idx] <= 1'b1;
          btb_tag[u_idx]   <= u_tag;
          btb_tgt[u_idx]   <= target;
          btb_cnt[u_idx]   <= 2'b10;
        end
      end
    end
  end

  assign pc          = pc_q;
  assign mispred_cnt = mis_q;

endmodule

// File: tb/tb_npc_bpred.sv
module tb_npc_bpred;

  localparam logic [2:0] OP_PLUS4  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_BNE    = 3'd2;
  localparam logic [2:0] OP_JUMP   = 3'd3;
  localparam logic [2:0] OP_JAL    = 3'd4;
  localparam logic [2:0] OP_JR     = 3'd5;
  localparam logic [2:0] OP_JALR   = 3'd6;
  localparam logic [31:0] HELPER_PC = 32'h0000_403C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        harzard;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [2:0]  id_npcop;
  logic        id_zero;
  logic [25:0] id_imm26;
  logic [15:0] id_imm16;
  logic [31:0] id_rs;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        flush;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  npc_bpred dut (
    .clk(clk), .rst(rst), .harzard(harzard), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_npcop(id_npcop),
    .id_zero(id_zero), .id_imm26(id_imm26), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .flush(flush),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: BTB as plain arrays, counters as integers 0..3.
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  logic [31:0] m_pc;
  int          m_mcnt;
  bit          m_pt, m_mis, m_res, m_tk;
  logic [31:0] m_ptgt, m_tg, m_act;

  task automatic model_reset();
    m_pc = 32'h3000; m_mcnt = 0;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
  endtask

  task automatic model_eval();
    int idx, off;
    logic [31:0] p4;
    idx    = int'((m_pc / 4) % 16);
    m_pt   = m_v[idx] && (m_tag[idx] == m_pc / 64) && (m_cnt[idx] >= 2);
    m_ptgt = (m_v[idx] && (m_tag[idx] == m_pc / 64)) ? m_tgt[idx] : 32'h0;
    m_res  = id_valid && !harzard && (id_npcop != OP_PLUS4);
    p4     = id_pc + 32'd4;
    off    = int'($signed(id_imm16));
    m_tk = 0; m_tg = p4;
    case (id_npcop)
      OP_BRANCH: begin m_tk = id_zero;  m_tg = p4 + 32'(off * 4); end
      OP_BNE:    begin m_tk = !id_zero; m_tg = p4 + 32'(off * 4); end
      OP_JUMP, OP_JAL: begin
        m_tk = 1; m_tg = (p4 & 32'hF000_0000) | (32'(id_imm26) * 4);
      end
      OP_JR, OP_JALR: begin m_tk = 1; m_tg = id_rs; end
      default: ;
    endcase
    m_act = m_tk ? m_tg : p4;
    m_mis = m_res && ((id_pred_taken != m_tk) || (m_tk && id_pred_target != m_tg));
  endtask

  task automatic model_commit();
    int i;
    bit hit;
    if (m_mis) m_pc = m_act;
    else if (!harzard) m_pc = m_pt ? m_ptgt : m_pc + 32'd4;
    if (m_mis && m_mcnt < 65535) m_mcnt++;
    if (m_res) begin
      i   = int'((id_pc / 4) % 16);
      hit = m_v[i] && (m_tag[i] == id_pc / 64);
      if (hit && m_tk) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = m_tg;
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (m_tk) begin
        m_v[i] = 1; m_tag[i] = id_pc / 64; m_tgt[i] = m_tg; m_cnt[i] = 2;
      end
    end
  endtask

  task automatic set_idle();
    harzard = 0; id_valid = 0; id_pc = 0; id_npcop = OP_PLUS4; id_zero = 0;
    id_imm26 = 0; id_imm16 = 0; id_rs = 0; id_pred_taken = 0; id_pred_target = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic drive_br(input logic [2:0] op, input logic [31:0] a,
                          input logic [15:0] imm, input logic z,
                          input logic pt, input logic [31:0] ptg);
    set_idle();
    id_valid = 1; id_npcop = op; id_pc = a; id_imm16 = imm; id_zero = z;
    id_pred_taken = pt; id_pred_target = ptg;
  endtask

  // Steers fetch to addr through a JR mispredict resolved at HELPER_PC.
  task automatic redirect(input logic [31:0] addr);
    set_idle();
    id_valid = 1; id_pc = HELPER_PC; id_npcop = OP_JR; id_rs = addr;
    settle();
    step();
    set_idle();
    settle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    id_valid = 1; id_npcop = OP_JUMP; id_pc = 32'h3000;
    #1;
    checks++;
    if (flush !== 1'b0 || pc !== 32'h3000 || pred_taken !== 1'b0 || mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold flush=%b pc=%h pt=%b cnt=%0d want 0 3000 0 0",
               flush, pc, pred_taken, mispred_cnt);
    end
    @(negedge clk);
    rst = 0;
    set_idle();
    model_reset();
    settle();
    checks++;
    if (pc !== 32'h3000 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_release pc=%h pt=%b ptg=%h want 3000 0 0", pc, pred_taken, pred_target);
    end
    step(); settle();
    checks++;
    if (pc !== 32'h3004) begin errors++; $display("FAIL reset_pc1 got %h want 3004", pc); end
    step(); settle();
    checks++;
    if (pc !== 32'h3008) begin errors++; $display("FAIL reset_pc2 got %h want 3008", pc); end
  endtask

  task automatic test_cold_branch();
    drive_br(OP_BRANCH, 32'h3010, 16'h0004, 1, 0, 0);
    settle();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL cold_flush got %b want 1", flush); end
    step(); set_idle(); settle();
    checks++;
    if (pc !== 32'h3024 || mispred_cnt !== 16'd1) begin
      errors++; $display("FAIL cold_redirect pc=%h cnt=%0d want 3024 1", pc, mispred_cnt);
    end
    redirect(32'h3010);
    checks++;
    if (pc !== 32'h3010 || pred_taken !== 1'b1 || pred_target !== 32'h3024) begin
      errors++;
      $display("FAIL cold_predict pc=%h pt=%b ptg=%h want 3010 1 3024", pc, pred_taken, pred_target);
    end
    step(); settle();
    checks++;
    if (pc !== 32'h3024) begin errors++; $display("FAIL cold_follow pc=%h want 3024", pc); end
  endtask

  task automatic test_hysteresis();
    for (int k = 0; k < 2; k++) begin
      drive_br(OP_BRANCH, 32'h3010, 16'h0004, 1, 1, 32'h3024);
      settle();
      checks++;
      if (flush !== 1'b0) begin errors++; $display("FAIL hyst_taken%0d flush=%b want 0", k, flush); end
      step();
    end
    drive_br(OP_BRANCH, 32'h3010, 16'h0004, 0, 1, 32'h3024);
    settle();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL hyst_nt1_flush got %b want 1", flush); end
    step(); set_idle(); settle();
    checks++;
    if (pc !== 32'h3014) begin errors++; $display("FAIL hyst_nt1_pc got %h want 3014", pc); end
    redirect(32'h3010);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL hyst_cnt10 pt=%b want 1", pred_taken); end
    drive_br(OP_BRANCH, 32'h3010, 16'h0004, 0, 1, 32'h3024);
    settle();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL hyst_nt2_flush got %b want 1", flush); end
    step();
    redirect(32'h3010);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h3024) begin
      errors++; $display("FAIL hyst_cnt01 pt=%b ptg=%h want 0 3024", pred_taken, pred_target);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    logic [15:0] c0;
    drive_br(OP_BNE, 32'h3100, 16'h0010, 0, 0, 0);
    harzard = 1;
    settle();
    p0 = pc; c0 = mispred_cnt;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (flush !== 1'b0 || pc !== p0 || mispred_cnt !== c0) begin
        errors++;
        $display("FAIL stall_hold%0d flush=%b pc=%h cnt=%0d want 0 %h %0d", k, flush, pc, mispred_cnt, p0, c0);
      end
      step(); settle();
    end
    harzard = 0;
    settle();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL stall_release flush=%b want 1", flush); end
    step(); set_idle(); settle();
    checks++;
    if (pc !== 32'h3144 || mispred_cnt !== c0 + 16'd1) begin
      errors++; $display("FAIL stall_redirect pc=%h cnt=%0d want 3144 %0d", pc, mispred_cnt, c0 + 16'd1);
    end
    redirect(32'h3100);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3144 || pred_taken !== m_pt) begin
      errors++; $display("FAIL stall_btb pt=%b ptg=%h want 1 3144", pred_taken, pred_target);
    end
  endtask

  task automatic test_jr();
    set_idle();
    id_valid = 1; id_npcop = OP_JR; id_pc = 32'h3208; id_rs = 32'h3100;
    settle(); step();
    redirect(32'h3208);
    checks++;
    if (pred_target !== 32'h3100) begin errors++; $display("FAIL jr_alloc ptg=%h want 3100", pred_target); end
    set_idle();
    id_valid = 1; id_npcop = OP_JALR; id_pc = 32'h3208; id_rs = 32'h3200;
    id_pred_taken = 1; id_pred_target = 32'h3100;
    settle();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL jr_flush got %b want 1", flush); end
    step(); set_idle(); settle();
    checks++;
    if (pc !== 32'h3200) begin errors++; $display("FAIL jr_pc got %h want 3200", pc); end
    redirect(32'h3208);
    checks++;
    if (pred_target !== 32'h3200) begin errors++; $display("FAIL jr_retarget ptg=%h want 3200", pred_target); end
  endtask

  task automatic test_alias();
    redirect(32'h3050);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++; $display("FAIL alias_miss pt=%b ptg=%h want 0 0", pred_taken, pred_target);
    end
    drive_br(OP_BRANCH, 32'h3050, 16'h0000, 1, 0, 0);
    settle(); step();
    redirect(32'h3010);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++; $display("FAIL alias_evicted pt=%b ptg=%h want 0 0", pred_taken, pred_target);
    end
    redirect(32'h3050);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3054) begin
      errors++; $display("FAIL alias_replace pt=%b ptg=%h want 1 3054", pred_taken, pred_target);
    end
  endtask

  task automatic drive_random();
    logic [31:0] addrs [5];
    addrs[0] = 32'h3010; addrs[1] = 32'h3050; addrs[2] = 32'h3100;
    addrs[3] = 32'h3208; addrs[4] = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
    harzard        = ($urandom_range(0, 4) == 0);
    id_valid       = ($urandom_range(0, 3) != 0);
    id_pc          = addrs[$urandom_range(0, 4)];
    id_npcop       = 3'($urandom_range(0, 6));
    id_zero        = 1'($urandom);
    id_imm26       = 26'($urandom_range(32'h0C00, 32'h0C3F));
    id_imm16       = 16'($signed($urandom_range(0, 40)) - 20);
    id_rs          = addrs[$urandom_range(0, 4)];
    id_pred_taken  = 1'($urandom);
    id_pred_target = ($urandom_range(0, 1) == 0) ? m_pc : addrs[$urandom_range(0, 4)];
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_random();
      settle();
      checks++;
      if (pc !== m_pc || pred_taken !== m_pt || pred_target !== m_ptgt ||
          flush !== m_mis || mispred_cnt !== 16'(m_mcnt)) begin
        errors++;
        $display("FAIL rand%0d pc=%h pt=%b ptg=%h fl=%b cnt=%0d want %h %b %h %b %0d",
                 k, pc, pred_taken, pred_target, flush, mispred_cnt,
                 m_pc, m_pt, m_ptgt, m_mis, m_mcnt);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    drive_random();
    settle();
    #2;
    rst = 1;
    #1;
    checks++;
    if (pc !== 32'h3000 || pred_taken !== 1'b0 || pred_target !== 32'h0 ||
        mispred_cnt !== 16'd0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pc=%h pt=%b ptg=%h cnt=%0d fl=%b want 3000 0 0 0 0",
               pc, pred_taken, pred_target, mispred_cnt, flush);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    set_idle();
    settle();
    checks++;
    if (pc !== 32'h3000) begin errors++; $display("FAIL async_release pc=%h want 3000", pc); end
    redirect(32'h3010);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++; $display("FAIL async_btb_clear pt=%b ptg=%h want 0 0", pred_taken, pred_target);
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_cold_branch();
    test_hysteresis();
    test_stall();
    test_jr();
    test_alias();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Next-generation next-PC unit for the pipelined MIPS core. Holds the fetch PC register and predicts the next fetch address from a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves branches and jumps in ID, then redirects fetch and raises flush on a misprediction.
- Replaces the purely combinational next-PC selection with a stateful, predictive fetch front end.

Parameters:
- ADDR_W, 32: PC and target width.
- BTB_ENTRIES, 16: BTB depth; power of two, minimum 2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- CNT_INIT, 2'b01: counter value after reset.
- STAT_W, 16: width of the misprediction counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- harzard, input, 1: fetch/decode stall; the PC holds.
- pc, output, ADDR_W: current fetch PC (register).
- pred_taken, output, 1: prediction for pc; pipelined with the instruction by the IF/ID register.
- pred_target, output, ADDR_W: predicted target for pc; valid when pred_taken=1.
- id_valid, input, 1: the ID-stage instruction is real (not a bubble).
- id_pc, input, ADDR_W: PC of the ID instruction.
- id_npcop, input, 3: next-PC op, using the existing `NPC_* encodings.
- id_zero, input, 1: comparator equal flag.
- id_imm26, input, 26: jump index.
- id_imm16, input, 16: branch offset.
- id_rs, input, ADDR_W: register target for JR/JALR.
- id_pred_taken, input, 1: prediction carried with the ID instruction.
- id_pred_target, input, ADDR_W: predicted target carried with the ID instruction.
- flush, output, 1: combinational; kill the IF instruction.
- mispred_cnt, output, STAT_W: saturating misprediction count.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, pred_taken=0, pred_target=0, mispred_cnt=0.
  - All BTB valid bits=0, counters=CNT_INIT.
  - flush=0 while in reset.
- Lookup (combinational on pc):
  - idx=pc[IDX_W+1:2], tag=pc[ADDR_W-1:IDX_W+2].
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[idx][1]; pred_target = target[idx] when hit, else 0.
- Resolution: active when res = id_valid && !harzard && id_npcop != `NPC_PLUS4.
  - ID_PCPLUS4 = id_pc+4.
  - BRANCH: taken=id_zero. BNE: taken=!id_zero. Branch target = ID_PCPLUS4 + (sext(id_imm16)<<2).
  - JUMP/JAL: taken=1, target = {ID_PCPLUS4[31:28], id_imm26, 2'b00}.
  - JR/JALR: taken=1, target = id_rs.
  - actual_next = taken ? target : ID_PCPLUS4.
  - mispredict = res && (id_pred_taken != taken || (taken && id_pred_target != target)).
  - flush = mispredict.
- PC update at each clk edge, in priority order:
  1. mispredict: pc <= actual_next.
  2. harzard: pc holds.
  3. pred_taken: pc <= pred_target.
  4. Otherwise: pc <= pc+4.
  - Arithmetic wraps modulo 2^ADDR_W.
- BTB update (only when res=1, at the clock edge; the ID entry is indexed by id_pc):
  - hit and taken: counter increments, saturating at 11; target is rewritten.
  - hit and not taken: counter decrements, saturating at 00.
  - miss and taken: allocate the entry (valid=1, tag, target, counter=2'b10), overwriting any alias.
  - miss and not taken: no change.
- Same-cycle lookup and update of one index: the lookup sees the pre-update contents.
- mispred_cnt increments on each mispredict and saturates at all-ones.
- harzard=1 suppresses resolution, BTB update and flush. The upstream holds the ID instruction, so it resolves once the stall releases.
- Reset asserted mid-operation clears all state immediately; there is no partial update.

Test Plan:
- Reset: assert rst, then release → pc=32'h3000 and pred_taken=0; the next two edges give pc=3004, then 3008.
- Cold taken BEQ: id_pc=3010, imm16=0004, zero=1, id_pred_taken=0 → flush=1, next pc=3024, mispred_cnt=1. A later fetch of 3010 gives pred_taken=1, pred_target=3024, and pc goes to 3024.
- Counter hysteresis on the 3010 entry: 2 more taken resolutions → cnt=11. One not-taken → cnt=10, still predicts taken, and that resolution raises flush with pc=3014. A second not-taken → cnt=01, pred_taken=0.
- Stall: harzard=1 for 3 cycles while ID holds a mispredicted BNE → pc constant, flush=0, BTB unchanged. On release, flush=1 and the redirect occurs.
- JR target mismatch: id_pred_taken=1, id_pred_target=3100, id_rs=3200 → flush=1, pc=3200, stored target becomes 3200.
- Aliasing, BTB_ENTRIES=16: allocate 3010, then fetch 3050 (same idx, different tag) → pred_taken=0. A taken branch resolved at 3050 replaces the entry, and a subsequent fetch of 3010 misses.
